// File: rtl/memsim_pkg.sv
// Shared types and helpers for the memory-system simulation models.
package memsim_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRECHARGE = 2'd1,
        ACTIVATE  = 2'd2,
        ACCESS    = 2'd3
    } dram_state_t;

    // Phase counter holds (cycles-1), so clog2 of the longest phase suffices; never below 1 bit.
    function automatic int unsigned phase_cnt_width(input int unsigned cas,
                                                    input int unsigned ras,
                                                    input int unsigned pre);
        int unsigned m;
        m = cas;
        if (ras > m) m = ras;
        if (pre > m) m = pre;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dram_model_if.sv
// Cache-to-main-memory port: request bus, read data, ready and statistics counters.
interface dram_model_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned WORD_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] din;
    logic [WORD_WIDTH-1:0] dout;
    logic                  re;
    logic                  we;
    logic                  ready;
    logic [31:0]           row_hits;
    logic [31:0]           row_misses;

    modport master (
        output addr, din, re, we,
        input  dout, ready, row_hits, row_misses
    );

    modport slave (
        input  addr, din, re, we,
        output dout, ready, row_hits, row_misses
    );
endinterface

// File: rtl/dram_storage.sv
// Synchronous single-port word array with write enable and a registered, enabled read port.
module dram_storage #(
    parameter int unsigned SIZE_BITS  = 10,
    parameter int unsigned WORD_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [SIZE_BITS-1:0]  addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);
    localparam int unsigned DEPTH = 2 ** SIZE_BITS;

    // Array contents are deliberately not reset.
    logic [WORD_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/dram_model.sv
// Open-row DRAM timing model: word storage plus PRE/RAS/CAS latency FSM and row hit/miss statistics.
module dram_model
    import memsim_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned WORD_WIDTH = 64,
    parameter int unsigned SIZE_BITS  = 10,
    parameter int unsigned ROW_BITS   = 3,
    parameter int unsigned CAS_CYCLES = 2,
    parameter int unsigned RAS_CYCLES = 3,
    parameter int unsigned PRE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    dram_model_if.slave bus
);
    localparam int unsigned CNT_W = phase_cnt_width(CAS_CYCLES, RAS_CYCLES, PRE_CYCLES);
    localparam int unsigned ROW_W = SIZE_BITS - ROW_BITS;

    localparam logic [CNT_W-1:0] CAS_LOAD = CNT_W'(CAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RAS_LOAD = CNT_W'(RAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);

    dram_state_t           state;
    logic [CNT_W-1:0]      cnt;
    logic                  open_valid;
    logic [ROW_W-1:0]      open_row;
    logic [SIZE_BITS-1:0]  idx;
    logic [WORD_WIDTH-1:0] wdata;
    logic                  is_read;
    logic                  ready;
    logic [31:0]           hits;
    logic [31:0]           misses;
    logic [WORD_WIDTH-1:0] rd_data;

    logic [SIZE_BITS-1:0]  req_idx_c;
    logic [ROW_W-1:0]      req_row_c;
    logic                  done_c;
    logic                  mem_we_c;
    logic                  mem_re_c;
    logic                  unused_addr_c;

    // Upper address bits are ignored, so addresses alias modulo the storage depth.
    assign req_idx_c     = bus.addr[SIZE_BITS-1:0];
    assign req_row_c     = req_idx_c[SIZE_BITS-1:ROW_BITS];
    assign unused_addr_c = ^bus.addr[ADDR_WIDTH-1:SIZE_BITS];

    always_comb begin
        done_c   = 1'b0;
        mem_we_c = 1'b0;
        mem_re_c = 1'b0;
        if (state == ACCESS && cnt == '0) begin
            done_c   = 1'b1;
            mem_we_c = ~is_read;
            mem_re_c = is_read;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            open_valid <= 1'b0;
            open_row   <= '0;
            idx        <= '0;
            wdata      <= '0;
            is_read    <= 1'b0;
            ready      <= 1'b1;
            hits       <= '0;
            misses     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.re || bus.we) begin
                        idx        <= req_idx_c;
                        wdata      <= bus.din;
                        is_read    <= bus.re;
                        ready      <= 1'b0;
                        open_valid <= 1'b1;
                        open_row   <= req_row_c;
                        if (open_valid && open_row == req_row_c) begin
                            state <= ACCESS;
                            cnt   <= CAS_LOAD;
                            if (hits != '1) hits <= hits + 32'd1;
                        end else begin
                            state <= open_valid ? PRECHARGE : ACTIVATE;
                            cnt   <= open_valid ? PRE_LOAD : RAS_LOAD;
                            if (misses != '1) misses <= misses + 32'd1;
                        end
                    end
                end
                PRECHARGE: begin
                    if (cnt == '0) begin
                        state <= ACTIVATE;
                        cnt   <= RAS_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACTIVATE: begin
                    if (cnt == '0) begin
                        state <= ACCESS;
                        cnt   <= CAS_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACCESS: begin
                    if (done_c) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    dram_storage #(
        .SIZE_BITS (SIZE_BITS),
        .WORD_WIDTH(WORD_WIDTH)
    ) u_storage (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we_c),
        .re   (mem_re_c),
        .addr (idx),
        .wdata(wdata),
        .rdata(rd_data)
    );

    assign bus.dout       = rd_data;
    assign bus.ready      = ready;
    assign bus.row_hits   = hits;
    assign bus.row_misses = misses;
endmodule
